// File: rtl/demux_route_pkg.sv
// Shared types for the result demux controller: FSM encoding and queue entry layout.
package demux_route_pkg;

    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } route_state_t;

    typedef struct packed {
        logic                      sel;
        logic [DATA_W_DEFAULT-1:0] data;
    } route_entry_t;

endpackage

// File: rtl/demux_route_ctrl_if.sv
// Producer-side and destination-side handshakes of the result demux.
interface demux_route_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_sel;
    logic              out0_valid;
    logic              out0_ready;
    logic [DATA_W-1:0] out0_data;
    logic              out1_valid;
    logic              out1_ready;
    logic [DATA_W-1:0] out1_data;

    modport master (
        output in_valid, in_data, in_sel, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data
    );
endinterface

// File: rtl/demux_route_ctrl_route_fifo.sv
// Circular queue of {sel, data} entries; head is always visible on rdata.
module route_fifo
    import demux_route_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = route_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  entry_t                   wdata,
    output entry_t                   rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/demux_route_ctrl.sv
// Queued 1:2 result demux: FIFO of tagged words, one registered offer at a time.
module demux_route_ctrl
    import demux_route_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   flush,
    demux_route_ctrl_if.slave      bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy
);
    typedef struct packed {
        logic              sel;
        logic [DATA_W-1:0] data;
    } entry_t;

    route_state_t      state, state_nxt;
    entry_t            wdata, rdata;
    logic              full, empty, push, pop, xfer;
    logic              v0, v1, v0_nxt, v1_nxt;
    logic [DATA_W-1:0] d0, d1, d0_nxt, d1_nxt;

    assign bus.in_ready = !full && !flush;
    assign push         = bus.in_valid && bus.in_ready;
    assign wdata        = '{sel: bus.in_sel, data: bus.in_data};
    // A ready seen during flush is not a transfer.
    assign xfer = !flush && ((v0 && bus.out0_ready) || (v1 && bus.out1_ready));
    assign pop  = !flush && en && !empty && (state == IDLE || xfer);

    route_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wdata),
        .rdata (rdata),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nxt = state;
        v0_nxt    = v0;
        v1_nxt    = v1;
        d0_nxt    = d0;
        d1_nxt    = d1;
        if (flush) begin
            state_nxt = IDLE;
            v0_nxt    = 1'b0;
            v1_nxt    = 1'b0;
        end else if (pop) begin
            // Pop on a transfer keeps OFFER with no bubble.
            state_nxt = OFFER;
            v0_nxt    = !rdata.sel;
            v1_nxt    = rdata.sel;
            if (rdata.sel) d1_nxt = rdata.data;
            else           d0_nxt = rdata.data;
        end else if (xfer) begin
            state_nxt = IDLE;
            v0_nxt    = 1'b0;
            v1_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            v0    <= 1'b0;
            v1    <= 1'b0;
            d0    <= '0;
            d1    <= '0;
        end else begin
            state <= state_nxt;
            v0    <= v0_nxt;
            v1    <= v1_nxt;
            d0    <= d0_nxt;
            d1    <= d1_nxt;
        end
    end

    assign bus.out0_valid = v0;
    assign bus.out0_data  = d0;
    assign bus.out1_valid = v1;
    assign bus.out1_data  = d1;
    assign busy           = (state != IDLE) || (count != '0);
endmodule
